// File: rtl/mem_access_unit_pkg.sv
// Shared encodings, state enum and access-legality helper for the memory access unit.
package mem_access_unit_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned OFF_W      = $clog2(WORD_BYTES);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  // Misaligned half/word or the reserved size encoding.
  function automatic logic is_bad_access(logic [1:0] size, logic [OFF_W-1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != '0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle; master is the CPU memory stage, slave is the unit.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/mau_lane.sv
// Little-endian lane extraction (with sign/zero extension) and lane merge for sub-word stores.
module mau_lane
  import mem_access_unit_pkg::*;
(
  input  logic [31:0]      word,
  input  logic [OFF_W-1:0] addr,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [31:0]      wdata,
  output logic [31:0]      load_data,
  output logic [31:0]      merged_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  always_comb begin
    byte_val    = word[{addr, 3'b000} +: 8];
    half_val    = word[{addr[1], 4'b0000} +: 16];
    load_data   = word;
    merged_word = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
        merged_word[{addr, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_val[15]}}, half_val};
        merged_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Turns byte/half/word CPU loads and stores into word-wide RAM transactions (RMW for sub-word).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  cpu,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state_q, state_d;
  logic              we_q, sign_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [31:0]       load_data, merged_word;
  logic              accept, bad;

  assign accept = cpu.req_valid & (state_q == IDLE);
  assign bad    = is_bad_access(cpu.req_size, cpu.req_addr[OFF_W-1:0]);

  mau_lane u_lane (
    .word        (mem_rdata),
    .addr        (addr_q[OFF_W-1:0]),
    .size        (size_q),
    .sign_ext    (sign_q),
    .wdata       ({16'h0000, wdata_q}),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (cpu.req_valid) begin
          if (bad) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (cpu.req_we && cpu.req_size == SZ_WORD) begin
            state_d     = WR;
            mem_wdata_d = cpu.req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (we_q) begin
          state_d     = WR;
          mem_wdata_d = merged_word;
        end else begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      if (accept) begin
        we_q    <= cpu.req_we;
        sign_q  <= cpu.req_signed;
        size_q  <= cpu.req_size;
        addr_q  <= cpu.req_addr;
        wdata_q <= cpu.req_wdata[15:0];
      end
    end
  end

  // Ready is forced low while reset is held, not just via the state register.
  assign cpu.req_ready  = rst & (state_q == IDLE);
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_err   = resp_err_q;
  assign cpu.resp_rdata = resp_rdata_q;

  assign mem_rd_en = (state_q == RD);
  assign mem_wr_en = (state_q == WR);
  assign mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 1-cycle-latency word RAM.
module tb_mem_access_unit;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ram [0:63];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int busy_ready = 0;
  int last_acc = -1;
  int last_wr_cyc = -1;
  logic [31:0] last_wdata = '0;

  exp_t sb_q[$];
  int   acc_q[$];
  int   acc_hist[$];

  mem_access_unit_if #(.ADDR_W(16)) bus ();

  mem_access_unit #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (bus),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr[7:2]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr[7:2]];
  end

  // Latency is the number of clock edges between the accepting edge and the response cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.resp_valid) begin
        checks++;
        if (sb_q.size() == 0 || acc_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got err=%0b rdata=%08h, required no response",
                   bus.resp_err, bus.resp_rdata);
        end else begin
          exp_t e;
          int   a;
          e = sb_q.pop_front();
          a = acc_q.pop_front();
          if (bus.resp_err !== e.err || bus.resp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                     e.name, bus.resp_err, bus.resp_rdata, e.err, e.rdata);
          end
          checks++;
          if (cyc - a !== e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d, required %0d", e.name, cyc - a, e.lat);
          end
        end
      end
      if (mem_rd_en || mem_wr_en) begin
        checks++;
        if (mem_rd_en && mem_wr_en) begin
          errors++;
          $display("FAIL rd_wr_overlap: got rd=1 wr=1, required at most one");
        end
        if (bus.req_ready) busy_ready++;
      end
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        last_wdata  = mem_wdata;
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_q.push_back(cyc + 1);
        acc_hist.push_back(cyc + 1);
        last_acc = cyc + 1;
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [15:0] addr, input logic [31:0] wdata);
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 20);
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got ready=0 after %0d cycles, required ready=1", name, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    exp_t e;
    @(posedge clk);
    #1;
    drive(we, size, sgn, addr, wdata);
    e.name  = name;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    wait_accept(name);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending responses, required 0", name, sb_q.size());
      sb_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 16'h0000, 32'h0);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %0b, required 0", bus.req_ready);
    end
    checks++;
    if ({bus.resp_valid, bus.resp_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_resp: got %02b, required 00", {bus.resp_valid, bus.resp_err});
    end
    checks++;
    if ({mem_rd_en, mem_wr_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mem_en: got %02b, required 00", {mem_rd_en, mem_wr_en});
    end
    checks++;
    if ({mem_addr, mem_wdata, bus.resp_rdata} !== 80'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%04h wdata=%08h rdata=%08h, required all 0",
               mem_addr, mem_wdata, bus.resp_rdata);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b, required 1", bus.req_ready);
    end
  endtask

  task automatic test_word();
    issue("word_store", 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0, 1);
    wait_done("word_store");
    checks++;
    if (last_wr_cyc !== last_acc) begin
      errors++;
      $display("FAIL word_store_wr_cycle: got %0d, required %0d", last_wr_cyc, last_acc);
    end
    checks++;
    if (ram[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_store_ram: got %08h, required deadbeef", ram[4]);
    end
    issue("word_load", 1'b0, 2'd2, 1'b1, 16'h0010, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    wait_done("word_load");
  endtask

  task automatic test_load_ext();
    @(negedge clk);
    ram[4] <= 32'h80FF7F01;
    issue("ld_b13_s", 1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, 1'b0, 32'hFFFFFF80, 2);
    issue("ld_b13_u", 1'b0, 2'd0, 1'b0, 16'h0013, 32'h0, 1'b0, 32'h00000080, 2);
    issue("ld_h10_s", 1'b0, 2'd1, 1'b1, 16'h0010, 32'h0, 1'b0, 32'h00007F01, 2);
    issue("ld_h12_s", 1'b0, 2'd1, 1'b1, 16'h0012, 32'h0, 1'b0, 32'hFFFF80FF, 2);
    issue("ld_h12_u", 1'b0, 2'd1, 1'b0, 16'h0012, 32'h0, 1'b0, 32'h000080FF, 2);
    issue("ld_b11_u", 1'b0, 2'd0, 1'b0, 16'h0011, 32'h0, 1'b0, 32'h0000007F, 2);
    issue("ld_b12_s", 1'b0, 2'd0, 1'b1, 16'h0012, 32'h0, 1'b0, 32'hFFFFFFFF, 2);
    wait_done("load_ext");
  endtask

  task automatic test_subword_store();
    int rd0;
    @(negedge clk);
    ram[4] <= 32'h11223344;
    rd0 = rd_cnt;
    issue("st_b11", 1'b1, 2'd0, 1'b0, 16'h0011, 32'h123456AB, 1'b0, 32'h0, 3);
    wait_done("st_b11");
    checks++;
    if (last_wdata !== 32'h1122AB44) begin
      errors++;
      $display("FAIL st_b11_wdata: got %08h, required 1122ab44", last_wdata);
    end
    checks++;
    if (last_wr_cyc !== last_acc + 2) begin
      errors++;
      $display("FAIL st_b11_wr_cycle: got %0d, required %0d", last_wr_cyc, last_acc + 2);
    end
    checks++;
    if (rd_cnt - rd0 !== 1) begin
      errors++;
      $display("FAIL st_b11_reads: got %0d, required 1", rd_cnt - rd0);
    end
    issue("ld_after_b11", 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b0, 32'h1122AB44, 2);
    issue("st_h12", 1'b1, 2'd1, 1'b1, 16'h0012, 32'h99995566, 1'b0, 32'h0, 3);
    issue("ld_after_h12", 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b0, 32'h5566AB44, 2);
    issue("st_b13", 1'b1, 2'd0, 1'b0, 16'h0013, 32'h000000EE, 1'b0, 32'h0, 3);
    issue("ld_after_b13", 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b0, 32'hEE66AB44, 2);
    wait_done("subword_store");
  endtask

  task automatic test_errors();
    int rd0 = rd_cnt;
    int wr0 = wr_cnt;
    issue("err_h15", 1'b0, 2'd1, 1'b0, 16'h0015, 32'h0, 1'b1, 32'h0, 0);
    issue("err_w12", 1'b0, 2'd2, 1'b0, 16'h0012, 32'h0, 1'b1, 32'h0, 0);
    issue("err_sz3", 1'b0, 2'd3, 1'b0, 16'h0000, 32'h0, 1'b1, 32'h0, 0);
    issue("err_st_h13", 1'b1, 2'd1, 1'b0, 16'h0013, 32'hFFFF, 1'b1, 32'h0, 0);
    wait_done("errors");
    checks++;
    if (rd_cnt !== rd0 || wr_cnt !== wr0) begin
      errors++;
      $display("FAIL err_mem_access: got rd=%0d wr=%0d, required 0 0", rd_cnt - rd0, wr_cnt - wr0);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz [3] = '{2'd2, 2'd0, 2'd1};
    logic        sg [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] ad [3] = '{16'h0014, 16'h0019, 16'h001A};
    logic [31:0] ex [3] = '{32'h01020304, 32'h000000C7, 32'hFFFFA5B6};
    int h0, b0;
    @(negedge clk);
    ram[5] <= 32'h01020304;
    ram[6] <= 32'hA5B6C7D8;
    h0 = acc_hist.size();
    b0 = busy_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      drive(1'b0, sz[i], sg[i], ad[i], 32'h0);
      e.name  = $sformatf("b2b_%0d", i);
      e.err   = 1'b0;
      e.rdata = ex[i];
      e.lat   = 2;
      sb_q.push_back(e);
      wait_accept(e.name);
    end
    bus.req_valid = 1'b0;
    wait_done("b2b");
    checks++;
    if (acc_hist.size() - h0 !== 3) begin
      errors++;
      $display("FAIL b2b_accept_count: got %0d, required 3", acc_hist.size() - h0);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_hist[h0 + i] - acc_hist[h0 + i - 1] !== 3) begin
          errors++;
          $display("FAIL b2b_spacing_%0d: got %0d, required 3", i,
                   acc_hist[h0 + i] - acc_hist[h0 + i - 1]);
        end
      end
    end
    checks++;
    if (busy_ready !== b0) begin
      errors++;
      $display("FAIL b2b_ready_busy: got %0d busy cycles with ready, required 0", busy_ready - b0);
    end
  endtask

  task automatic test_reset_midop();
    int wr0;
    @(negedge clk);
    ram[8] <= 32'hCAFEF00D;
    wr0 = wr_cnt;
    issue("rst_h22", 1'b1, 2'd1, 1'b0, 16'h0022, 32'h00001234, 1'b0, 32'h0, 3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_wr_en, bus.resp_valid, bus.req_ready} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_outputs: got wr=%0b resp=%0b ready=%0b, required 000",
               mem_wr_en, bus.resp_valid, bus.req_ready);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: got ready=%0b rd=%0b, required 1 0", bus.req_ready, mem_rd_en);
    end
    checks++;
    if (wr_cnt !== wr0 || ram[8] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rst_mid_ram: got writes=%0d word=%08h, required 0 cafef00d",
               wr_cnt - wr0, ram[8]);
    end
    issue("rst_readback", 1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 1'b0, 32'hCAFEF00D, 2);
    wait_done("rst_readback");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
    test_reset();
    test_word();
    test_load_ext();
    test_subword_store();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
